// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// One 1-bit full_adder is stepped over WIDTH cycles, LSB first, to add two
// WIDTH-bit operands plus an initial carry. The result and final carry are
// registered and held until the next operation completes.
//
// Handshake: start is a request that is taken only on a clock edge where the
// controller is idle (busy=0 and done=0). The operands are captured on that
// same edge. busy stays high until the result lands. done is a one-cycle
// pulse that marks the cycle in which sum_out/c_out first show the new
// result. There is no back-pressure: the result is simply held.

// 1-bit full adder, purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_c_out;

  logic             w_fa_sum;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_s_next;
  logic             w_last_bit;

  // The single adder cell sees the current LSBs and the running carry.
  full_adder u_fa (
    .a     (r_a_sr[0]),
    .b     (r_b_sr[0]),
    .c_in  (r_carry),
    .sum   (w_fa_sum),
    .c_out (w_fa_c)
  );

  // New sum bit enters at the MSB and everything shifts right. Written as a
  // shift/or so that WIDTH=1 needs no special-cased slice.
  assign w_s_next   = (r_s_sr >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));
  assign w_last_bit = (r_count == CW'(WIDTH - 1));

  // Controller FSM with the datapath shift registers and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_s_sr    <= '0;
      r_carry   <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum_out <= '0;
      r_c_out   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr  <= a_in;
            r_b_sr  <= b_in;
            r_carry <= c_in_init;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_s_sr  <= w_s_next;
          r_carry <= w_fa_c;
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_count <= r_count + CW'(1);
          if (w_last_bit) begin
            // Publish the full result in one step so the outputs never
            // show a partially shifted value.
            r_sum_out <= w_s_next;
            r_c_out   <= w_fa_c;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // start is deliberately ignored here; the next accept is in IDLE.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum_out   = r_sum_out;
  assign c_out     = r_c_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a WIDTH=8 instance compared every cycle against
// a timing/arithmetic model, plus a WIDTH=1 instance driven through all
// eight {a,b,cin} combinations.
module tb_serial_add_ctrl;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset_n   = 1'b0;
  logic         start     = 1'b0;
  logic [W-1:0] a_in      = '0;
  logic [W-1:0] b_in      = '0;
  logic         c_in_init = 1'b0;
  logic         busy, done, c_out;
  logic [W-1:0] sum_out;
  logic [1:0]   dbg_state;

  logic       w1_start = 1'b0;
  logic [0:0] w1_a     = '0;
  logic [0:0] w1_b     = '0;
  logic       w1_cin   = 1'b0;
  logic       w1_busy, w1_done, w1_c;
  logic [0:0] w1_sum;
  logic [1:0] w1_dbg;

  serial_add_ctrl #(.WIDTH(W), .CW(6)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .a_in(a_in), .b_in(b_in),
    .c_in_init(c_in_init), .busy(busy), .done(done), .sum_out(sum_out),
    .c_out(c_out), .dbg_state(dbg_state)
  );

  serial_add_ctrl #(.WIDTH(1), .CW(2)) dut_w1 (
    .clock(clock), .reset_n(reset_n), .start(w1_start), .a_in(w1_a), .b_in(w1_b),
    .c_in_init(w1_cin), .busy(w1_busy), .done(w1_done), .sum_out(w1_sum),
    .c_out(w1_c), .dbg_state(w1_dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // An accepted operation produces its sum W edges later; the controller is
  // free to accept again two edges after that.
  bit           m_active  = 1'b0;
  int           m_end     = 0;
  int           m_free_at = 0;
  logic [W:0]   exp_q[$];
  logic         exp_busy  = 1'b0;
  logic         exp_done  = 1'b0;
  logic [W-1:0] exp_sum   = '0;
  logic         exp_c     = 1'b0;
  bit           chk_en    = 1'b0;

  always @(posedge clock) begin
    cyc++;
    if (!reset_n) begin
      m_active  = 1'b0;
      m_free_at = cyc + 1;
      exp_q.delete();
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_sum   = '0;
      exp_c     = 1'b0;
      chk_en    = 1'b1;
    end else begin
      exp_done = 1'b0;
      if (m_active && cyc == m_end) begin
        {exp_c, exp_sum} = exp_q.pop_front();
        exp_done  = 1'b1;
        m_active  = 1'b0;
        m_free_at = cyc + 2;
      end else if (!m_active && cyc >= m_free_at && start) begin
        exp_q.push_back({1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, c_in_init});
        m_active = 1'b1;
        m_end    = cyc + W;
      end
      exp_busy = m_active;
    end
  end

  // Compare process: every cycle once reset has been seen.
  always @(negedge clock) begin
    if (chk_en) begin
      check("busy",    32'(busy),    32'(exp_busy));
      check("done",    32'(done),    32'(exp_done));
      check("sum_out", 32'(sum_out), 32'(exp_sum));
      check("c_out",   32'(c_out),   32'(exp_c));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present an operation for one edge; returns the cycle number of that edge.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output int acc);
    start = 1'b1; a_in = a; b_in = b; c_in_init = c;
    tick();
    acc   = cyc;
    start = 1'b0;
    a_in  = W'($urandom); b_in = W'($urandom); c_in_init = 1'($urandom);
  endtask

  // Wait (bounded) for done; returns its cycle and how many busy samples preceded it.
  task automatic wait_done(input int budget, output int at, output int nbusy);
    at = -1; nbusy = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
      if (busy === 1'b1) nbusy++;
    end
    check("done_seen", 32'(at >= 0), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, at, at2, nb, ndone;
    logic [1:0] w1_tbl [8];
    w1_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // Reset for two edges, then literal reset-state checks.
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum_out), 32'd0);
    check("rst_c",    32'(c_out), 32'd0);
    reset_n = 1'b1;
    tick();

    // 0F + 01: eight busy cycles, done W edges after accept.
    op(8'h0F, 8'h01, 1'b0, acc);
    wait_done(40, at, nb);
    check("t1_busy_cycles", 32'(nb), 32'd8);
    check("t1_latency", 32'(at - acc), 32'd8);
    check("t1_sum", 32'(sum_out), 32'h10);
    check("t1_c",   32'(c_out), 32'd0);
    check("t1_model_sum", 32'(exp_sum), 32'h10);
    tick();

    // Carry out of the top bit.
    op(8'hFF, 8'h01, 1'b0, acc);
    wait_done(40, at, nb);
    check("t2a_sum", 32'(sum_out), 32'h00);
    check("t2a_c",   32'(c_out), 32'd1);
    tick();
    op(8'hFF, 8'hFF, 1'b1, acc);
    wait_done(40, at, nb);
    check("t2b_sum", 32'(sum_out), 32'hFF);
    check("t2b_c",   32'(c_out), 32'd1);
    tick();

    // Inputs toggled and start held during RUN/DONE must not disturb the result.
    op(8'h12, 8'h34, 1'b0, acc);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      start = 1'b1; a_in = 8'hAA; b_in = 8'h55; c_in_init = 1'b1;
      @(negedge clock);
      if (done === 1'b1) begin at = cyc; break; end
      #1;
    end
    check("t3_done_seen", 32'(at >= 0), 32'd1);
    check("t3_sum", 32'(sum_out), 32'h46);
    check("t3_c",   32'(c_out), 32'd0);
    tick();
    check("t3_no_restart", 32'(busy), 32'd0);
    start = 1'b0;
    tick();

    // Reset in the middle of RUN aborts cleanly.
    op(8'h80, 8'h80, 1'b0, acc);
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_sum",  32'(sum_out), 32'd0);
    check("t4_c",    32'(c_out), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
    end
    check("t4_no_done", 32'(ndone), 32'd0);
    tick();
    op(8'h80, 8'h80, 1'b0, acc);
    wait_done(40, at, nb);
    check("t4b_sum", 32'(sum_out), 32'h00);
    check("t4b_c",   32'(c_out), 32'd1);
    tick();

    // start held high: back-to-back operations every W+2 cycles.
    start = 1'b1; a_in = 8'h01; b_in = 8'h01; c_in_init = 1'b0;
    tick();
    a_in = 8'h02; b_in = 8'h02;
    wait_done(40, at, nb);
    check("t5_sum1", 32'(sum_out), 32'h02);
    wait_done(40, at2, nb);
    start = 1'b0;
    check("t5_sum2", 32'(sum_out), 32'h04);
    check("t5_period", 32'(at2 - at), 32'd10);
    tick(); tick();

    // Randomized traffic with occasional reset, checked by the model.
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom_range(0, 2) == 0);
      a_in      = W'($urandom);
      b_in      = W'($urandom);
      c_in_init = 1'($urandom);
      reset_n   = ($urandom_range(0, 79) != 0);
      tick();
    end
    reset_n = 1'b1; start = 1'b0;
    repeat (W + 4) tick();

    // WIDTH=1 instance: every {a,b,cin} combination.
    for (int v = 0; v < 8; v++) begin
      w1_a = 1'(v >> 2); w1_b = 1'(v >> 1); w1_cin = 1'(v);
      w1_start = 1'b1;
      tick();
      w1_start = 1'b0;
      @(negedge clock);
      check("w1_busy", 32'(w1_busy), 32'd1);
      check("w1_done_early", 32'(w1_done), 32'd0);
      @(negedge clock);
      check("w1_done", 32'(w1_done), 32'd1);
      check("w1_result", 32'({w1_c, w1_sum}), 32'(((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1)));
      check("w1_table", 32'({w1_c, w1_sum}), 32'(w1_tbl[v]));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
